// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit.
//  - lsu_state_t : access FSM states (IDLE, REQ, WAIT, DONE)
//  - F3_*        : AddressingControl (funct3) encodings for loads and stores
//  - SZ_*        : access size, taken from funct3[1:0]
//  - f3_supported: 1 when funct3 names a legal access
//  - lsu_byte_en : byte-enable pattern for a size and byte offset
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Size field shared by loads and stores (funct3[1:0]).
  localparam logic [1:0] SZ_BYTE = F3_SB[1:0];
  localparam logic [1:0] SZ_HALF = F3_SH[1:0];
  localparam logic [1:0] SZ_WORD = F3_SW[1:0];

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load lane select and sign/zero extension.
//  rdata_word in  32  word returned by data memory
//  offset     in  2   byte offset of the access (already forced aligned)
//  funct3     in  3   load type: lb, lh, lw, lbu, lhu; anything else -> 0
//  result     out 32  extended load value
// ---------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    byte_lane = rdata_word[7:0];
    case (offset)
      2'd1:    byte_lane = rdata_word[15:8];
      2'd2:    byte_lane = rdata_word[23:16];
      2'd3:    byte_lane = rdata_word[31:24];
      default: byte_lane = rdata_word[7:0];
    endcase

    half_lane = offset[1] ? rdata_word[31:16] : rdata_word[15:0];

    result = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   result = {{16{half_lane[15]}}, half_lane};
      F3_LW:   result = rdata_word;
      F3_LBU:  result = {24'h0, byte_lane};
      F3_LHU:  result = {16'h0, half_lane};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle data-memory access stage. Captures a load/store, drives a
// valid/ready memory port with byte enables, returns the extended load
// result and stalls the core until the access completes.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses (no request, misalign pulses with done). Without it, low address
// bits are forced aligned and misalign is tied to 0.
//
// Ports
//  clk, rst_n             clock, asynchronous active-low reset
//  mem_read, mem_write    op valid, held by the core until done
//  addr_ctrl [2:0]        funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr, wdata [31:0]     byte address, store data
//  stall                  freeze upstream while an access is outstanding
//  done                   one-cycle completion pulse, rdata valid
//  rdata [31:0]           extended load result, held until next done
//  misalign               misaligned-access flag (trap build only)
//  dmem_req/we/addr/be/wdata  request to data memory
//  dmem_ready             memory accepts request
//  dmem_rvalid/rdata      read response
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // only 32 is supported
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            addr_ctrl,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misalign,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  lsu_state_t            state;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  op_valid;
  logic [1:0]            off_eff;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [DATA_WIDTH-1:0] load_result;

  assign op_valid = mem_read | mem_write;

  // Offset used for lanes: half keeps only addr[1], word ignores both bits.
  always_comb begin
    off_eff = addr[1:0];
    case (addr_ctrl[1:0])
      SZ_HALF: off_eff = {addr[1], 1'b0};
      SZ_WORD: off_eff = 2'b00;
      default: off_eff = addr[1:0];
    endcase
  end

  // Replicate store data across lanes so byte enables alone pick the target.
  always_comb begin
    store_lanes = wdata;
    case (addr_ctrl[1:0])
      SZ_BYTE: store_lanes = {4{wdata[7:0]}};
      SZ_HALF: store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misaligned = f3_supported(addr_ctrl) &&
                      (((addr_ctrl[1:0] == SZ_HALF) && addr[0]) ||
                       ((addr_ctrl[1:0] == SZ_WORD) && (addr[1:0] != 2'b00)));
  assign misalign   = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign   = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata_word (dmem_rdata),
    .offset     (off_q),
    .funct3     (f3_q),
    .result     (load_result)
  );

  // Held low during reset so a core holding its op sees no stall.
  assign stall    = rst_n & (((state == ST_IDLE) & op_valid) |
                             (state == ST_REQ) | (state == ST_WAIT));
  assign done     = (state == ST_DONE);
  assign dmem_req = (state == ST_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every capture register is reset, so request and result outputs
      // read 0 during reset and any in-flight access is forgotten.
      state      <= ST_IDLE;
      off_q      <= '0;
      f3_q       <= '0;
      rdata      <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            // Request fields are registered here and stay stable through REQ.
            dmem_we    <= mem_write;  // read+write together is a store
            dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            dmem_be    <= lsu_byte_en(addr_ctrl, off_eff);
            dmem_wdata <= store_lanes;
            off_q      <= off_eff;
            f3_q       <= addr_ctrl;
            if (!f3_supported(addr_ctrl) || misaligned) begin
              rdata <= '0;
              state <= ST_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
              misalign_q <= misaligned;
`endif
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ready) state <= dmem_we ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            rdata <= load_result;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: each directed op pushes its expected memory request and
// expected completion into queues; a monitor pops and compares whenever the
// DUT hands a request to memory or pulses done. A responder process models
// the memory (programmable ready delay and read latency).
// Build with +define+LSU_MISALIGN_TRAP_EN to exercise the trap variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  addr_ctrl = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, done, misalign, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr_ctrl(addr_ctrl), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .misalign(misalign), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    string       name;
  } req_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
    string       name;
  } resp_exp_t;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];

  int total = 0;
  int bad   = 0;

  // memory model controls
  int          ready_delay = 0;
  int          rv_delay    = 1;
  logic [31:0] mem_word    = 32'h0;
  int          req_age     = 0;
  int          rv_cnt      = 0;
  logic        acc_read    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Memory responder: ready after ready_delay request cycles, rvalid rv_delay
  // cycles after a read is accepted. Read data is inverted when not valid.
  initial begin
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = ~mem_word;
      if (acc_read) begin
        rv_cnt   = rv_delay;
        acc_read = 1'b0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = mem_word;
        end
      end
      if (dmem_req) begin
        dmem_ready = (req_age >= ready_delay);
        req_age++;
      end else begin
        dmem_ready = 1'b0;
        req_age    = 0;
      end
    end
  end

  // Monitor: compares accepted requests and completions against the queues.
  initial begin
    req_exp_t  re;
    resp_exp_t rs;
    forever begin
      @(negedge clk);
      if (dmem_req && dmem_ready) begin
        acc_read = !dmem_we;
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(1), 32'(0));
        end else begin
          re = req_q.pop_front();
          check({re.name, "_we"},   32'(dmem_we), 32'(re.we));
          check({re.name, "_addr"}, dmem_addr, re.addr);
          check({re.name, "_be"},   32'(dmem_be), 32'(re.be));
          if (re.we) check({re.name, "_wdata"}, dmem_wdata, re.wdata);
        end
      end
      if (done) begin
        if (resp_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          rs = resp_q.pop_front();
          if (rs.chk_rdata) check({rs.name, "_rdata"}, rdata, rs.rdata);
          check({rs.name, "_misalign"}, 32'(misalign), 32'(rs.mis));
        end
      end
    end
  end

  // Issue one op, hold it until done, check latency, stall and request shape.
  task automatic do_op(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int rdy_dly, input int rv_dly, input logic [31:0] word,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata, input logic chk_rdata,
                       input logic exp_mis, input int exp_lat, input int exp_req_cycles);
    int          cyc;
    int          req_cycles;
    logic        stall_ok;
    logic        unstable;
    logic        got_done;
    logic [72:0] snap;
    if (exp_req) req_q.push_back('{wr, exp_addr, exp_be, exp_wdata, name});
    resp_q.push_back('{exp_rdata, chk_rdata, exp_mis, name});
    ready_delay = rdy_dly;
    rv_delay    = rv_dly;
    mem_word    = word;
    @(posedge clk);
    #1;
    mem_read  = rd;
    mem_write = wr;
    addr_ctrl = f3;
    addr      = a;
    wdata     = wd;
    req_cycles = 0;
    stall_ok   = 1'b1;
    unstable   = 1'b0;
    got_done   = 1'b0;
    snap       = '0;
    cyc        = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc = i;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      if (dmem_req) begin
        if (req_cycles == 0) snap = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
        else if (snap != {dmem_we, dmem_addr, dmem_be, dmem_wdata}) unstable = 1'b1;
        req_cycles++;
      end
    end
    if (!got_done) check({name, "_timeout"}, 32'(1), 32'(0));
    check({name, "_latency"},    32'(cyc), 32'(exp_lat));
    check({name, "_stall_busy"}, 32'(stall_ok), 32'(1));
    check({name, "_stall_done"}, 32'(stall), 32'(0));
    check({name, "_req_cycles"}, 32'(req_cycles), 32'(exp_req_cycles));
    check({name, "_req_stable"}, 32'(unstable), 32'(0));
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int done_cnt;
    logic accepted;
    // ---- reset state, with a load op already presented ----
    #3;
    mem_read = 1'b1;
    @(negedge clk);
    check("rst_stall",   32'(stall), 32'(0));
    check("rst_done",    32'(done), 32'(0));
    check("rst_req",     32'(dmem_req), 32'(0));
    check("rst_we",      32'(dmem_we), 32'(0));
    check("rst_be",      32'(dmem_be), 32'(0));
    check("rst_addr",    dmem_addr, 32'h0);
    check("rst_wdata",   dmem_wdata, 32'h0);
    check("rst_rdata",   rdata, 32'h0);
    check("rst_misalign", 32'(misalign), 32'(0));
    mem_read = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // name rd wr f3 addr wdata rdy rv word | req addr be wdata | rdata chk mis | lat reqc
    do_op("sw", 1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,
          1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, 1);
    do_op("lb", 1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 0, 2, 32'h80123456,
          1'b1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 4, 1);
    do_op("lbu", 1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 0, 2, 32'h80123456,
          1'b1, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b1, 1'b0, 4, 1);
    do_op("sh", 1'b0, 1'b1, F3_SH, 32'h22, 32'h1234ABCD, 0, 1, 32'h0,
          1'b1, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1'b0, 2, 1);
    do_op("lh", 1'b1, 1'b0, F3_LH, 32'h22, 32'h0, 0, 1, 32'hABCD0000,
          1'b1, 32'h20, 4'b1100, 32'h0, 32'hFFFFABCD, 1'b1, 1'b0, 3, 1);
    do_op("sw_slow", 1'b0, 1'b1, F3_SW, 32'h40, 32'h0BADF00D, 5, 1, 32'h0,
          1'b1, 32'h40, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, 7, 6);
    do_op("sb", 1'b0, 1'b1, F3_SB, 32'h201, 32'h000000A5, 0, 1, 32'h0,
          1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 2, 1);
    do_op("lhu", 1'b1, 1'b0, F3_LHU, 32'h30, 32'h0, 0, 1, 32'h1234F00D,
          1'b1, 32'h30, 4'b0011, 32'h0, 32'h0000F00D, 1'b1, 1'b0, 3, 1);
    do_op("lh_pos", 1'b1, 1'b0, F3_LH, 32'h10, 32'h0, 0, 1, 32'h00007FFF,
          1'b1, 32'h10, 4'b0011, 32'h0, 32'h00007FFF, 1'b1, 1'b0, 3, 1);
    do_op("rw_both", 1'b1, 1'b1, F3_SW, 32'h60, 32'h600DCAFE, 0, 1, 32'h0,
          1'b1, 32'h60, 4'b1111, 32'h600DCAFE, 32'h0, 1'b0, 1'b0, 2, 1);
    do_op("bad_f3", 1'b1, 1'b0, 3'b011, 32'h70, 32'h0, 0, 1, 32'hFFFFFFFF,
          1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
    do_op("lw", 1'b1, 1'b0, F3_LW, 32'h50, 32'h0, 0, 1, 32'hCAFEBABE,
          1'b1, 32'h50, 4'b1111, 32'h0, 32'hCAFEBABE, 1'b1, 1'b0, 3, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    do_op("lw_mis", 1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 0, 1, 32'h11223344,
          1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 1, 0);
    do_op("lh_mis", 1'b1, 1'b0, F3_LH, 32'h23, 32'h0, 0, 1, 32'hBEEF1234,
          1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 1, 0);
`else
    do_op("lw_mis", 1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 0, 1, 32'h11223344,
          1'b1, 32'h100, 4'b1111, 32'h0, 32'h11223344, 1'b1, 1'b0, 3, 1);
    do_op("lh_mis", 1'b1, 1'b0, F3_LH, 32'h23, 32'h0, 0, 1, 32'hBEEF1234,
          1'b1, 32'h20, 4'b1100, 32'h0, 32'hFFFFBEEF, 1'b1, 1'b0, 3, 1);
`endif
    do_op("lb_pre", 1'b1, 1'b0, F3_LB, 32'h81, 32'h0, 0, 1, 32'h00007F00,
          1'b1, 32'h80, 4'b0010, 32'h0, 32'h0000007F, 1'b1, 1'b0, 3, 1);

    // ---- reset while in WAIT; the late read response must be ignored ----
    ready_delay = 0;
    rv_delay    = 4;
    mem_word    = 32'h55AA55AA;
    req_q.push_back('{1'b0, 32'h80, 4'b1111, 32'h0, "rst_lw"});
    @(posedge clk);
    #1;
    mem_read  = 1'b1;
    addr_ctrl = F3_LW;
    addr      = 32'h80;
    wdata     = 32'h12345678;
    accepted  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req && dmem_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("rst_lw_accept", 32'(accepted), 32'(1));
    @(negedge clk);
    check("wait_stall", 32'(stall), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stall",    32'(stall), 32'(0));
    check("mid_rst_done",     32'(done), 32'(0));
    check("mid_rst_req",      32'(dmem_req), 32'(0));
    check("mid_rst_be",       32'(dmem_be), 32'(0));
    check("mid_rst_addr",     dmem_addr, 32'h0);
    check("mid_rst_wdata",    dmem_wdata, 32'h0);
    check("mid_rst_rdata",    rdata, 32'h0);
    check("mid_rst_misalign", 32'(misalign), 32'(0));
    mem_read = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("late_rvalid_no_done", 32'(done_cnt), 32'(0));

    // ---- normal operation after reset ----
    do_op("lbu_post", 1'b1, 1'b0, F3_LBU, 32'h82, 32'h0, 0, 1, 32'h00C30000,
          1'b1, 32'h80, 4'b0100, 32'h0, 32'h000000C3, 1'b1, 1'b0, 3, 1);

    repeat (3) @(negedge clk);
    check("req_q_empty",  32'(req_q.size()), 32'(0));
    check("resp_q_empty", 32'(resp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
